lcd_text_feeder: RTL and testbench

Feeds a 32-character text frame to the `lcd` driver over its `d_in`/`data_ready`/`busy_flag` handshake, acting as the initiator side of that interface. It holds a 2x16 character buffer written by the calculator core. On request it emits a full screen redraw: a DDRAM-address command, 16 characters, a second address command, then 16 more characters. Each word is paced by the driver's busy flag.

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_text_feeder_if.sv | 25 ++
 rtl/lcd_text_buf.sv | 32 +++
 rtl/lcd_text_feeder.sv | 140 ++++++++++++++
 tb/tb_lcd_text_feeder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD text feeder.
//   lcd_word_t      - 9-bit word {rs, data} sent to the LCD driver.
//   feeder_state_t  - feeder FSM states.
//   LCD_COLS / LCD_CHARS / LCD_LAST_STEP / LCD_SPACE - frame geometry and fill char.
package lcd_pkg;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_word_t;

    typedef enum logic [2:0] {
        BOOT_HI,
        BOOT_LO,
        IDLE,
        LOAD,
        STROBE,
        ACK,
        DONE
    } feeder_state_t;

    localparam int         LCD_COLS      = 16;
    localparam int         LCD_CHARS     = 32;
    localparam logic [5:0] LCD_LAST_STEP = 6'd33;
    localparam logic [7:0] LCD_SPACE     = 8'h20;

endpackage

// File: rtl/lcd_text_feeder_if.sv
// lcd_text_feeder_if: handshake between the text feeder (initiator) and the
// LCD driver.
//   d_out      - {RS, D[7:0]} word, feeder -> driver d_in
//   data_ready - one-cycle start strobe, feeder -> driver
//   lcd_busy   - driver busy_flag, driver -> feeder
// modport master: feeder side; modport slave: driver side.
interface lcd_text_feeder_if;

    logic [8:0] d_out;
    logic       data_ready;
    logic       lcd_busy;

    modport master (
        output d_out,
        output data_ready,
        input  lcd_busy
    );

    modport slave (
        input  d_out,
        input  data_ready,
        output lcd_busy
    );

endinterface

// File: rtl/lcd_text_buf.sv
// lcd_text_buf: 32x8 character store for a 2x16 display.
//   clock, internal_reset - clock and asynchronous active-high reset
//   we, wr_addr, wr_data  - synchronous write port
//   rd_addr, rd_data      - combinational read port
// Every entry resets to a space.
module lcd_text_buf
    import lcd_pkg::*;
(
    input  logic       clock,
    input  logic       internal_reset,
    input  logic       we,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [LCD_CHARS];

    always_ff @(posedge clock or posedge internal_reset) begin
        if (internal_reset) begin
            for (int i = 0; i < LCD_CHARS; i++) begin
                mem[i] <= LCD_SPACE;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_text_feeder.sv
// lcd_text_feeder: redraws a 2x16 text frame on the LCD driver.
// A frame is LINE1_CMD, 16 row-0 characters, LINE2_CMD, 16 row-1 characters,
// each word strobed once and paced by the driver's busy flag.
//   clock, internal_reset        - clock and asynchronous active-high reset
//   char_we, char_addr, char_data - character buffer write port
//   refresh                       - one-cycle redraw request
//   lcd (master)                  - d_out / data_ready / lcd_busy handshake
//   idle                          - no redraw running or pending
// Build option: LCD_TEXT_AUTO_REFRESH_EN makes every char_we also request a redraw.
module lcd_text_feeder
    import lcd_pkg::*;
#(
    parameter logic [8:0] LINE1_CMD   = 9'h080,
    parameter logic [8:0] LINE2_CMD   = 9'h0C0,
    parameter int         ACK_TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                internal_reset,
    input  logic                char_we,
    input  logic [4:0]          char_addr,
    input  logic [7:0]          char_data,
    input  logic                refresh,
    lcd_text_feeder_if.master   lcd,
    output logic                idle
);

    localparam int         TW         = $clog2(ACK_TIMEOUT + 1);
    localparam logic [5:0] LINE2_STEP = 6'(LCD_COLS + 1);
    // The counter holds the number of ACK cycles already spent; when the last
    // allowed cycle is reached the next strobe lands ACK_TIMEOUT+1 cycles
    // after the previous one.
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    feeder_state_t state, state_nx;
    logic [5:0]    step;
    logic          pending;
    logic          req;
    logic [TW-1:0] tmo_cnt;
    logic [4:0]    rd_addr;
    logic [7:0]    rd_data;
    logic [8:0]    word_nx;
    logic          start_frame;
    logic          word_done;

`ifdef LCD_TEXT_AUTO_REFRESH_EN
    assign req = refresh | char_we;
`else
    assign req = refresh;
`endif

    lcd_text_buf u_buf (
        .clock          (clock),
        .internal_reset (internal_reset),
        .we             (char_we),
        .wr_addr        (char_addr),
        .wr_data        (char_data),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data)
    );

    // Steps 1-16 read buf[step-1], steps 18-33 read buf[step-2]; the 5-bit
    // wrap of step[4:0] gives the right index for steps 32 and 33.
    assign rd_addr = step[4:0] - ((step <= 6'(LCD_COLS)) ? 5'd1 : 5'd2);

    always_comb begin
        word_nx = {1'b1, rd_data};
        if (step == 6'd0) begin
            word_nx = LINE1_CMD;
        end else if (step == LINE2_STEP) begin
            word_nx = LINE2_CMD;
        end
    end

    assign start_frame = (state == IDLE) && pending;
    assign word_done   = (state == DONE) && !lcd.lcd_busy;

    always_comb begin
        state_nx = state;
        case (state)
            BOOT_HI: if (lcd.lcd_busy)  state_nx = BOOT_LO;
            BOOT_LO: if (!lcd.lcd_busy) state_nx = IDLE;
            IDLE:    if (pending)       state_nx = LOAD;
            LOAD:                       state_nx = STROBE;
            STROBE:                     state_nx = ACK;
            ACK: begin
                if (lcd.lcd_busy) begin
                    state_nx = DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nx = STROBE;
                end
            end
            DONE: begin
                if (!lcd.lcd_busy) begin
                    state_nx = (step == LCD_LAST_STEP) ? IDLE : LOAD;
                end
            end
            default:                    state_nx = BOOT_HI;
        endcase
    end

    always_ff @(posedge clock or posedge internal_reset) begin
        if (internal_reset) begin
            state   <= BOOT_HI;
            step    <= 6'd0;
            pending <= 1'b0;
            tmo_cnt <= '0;
            lcd.d_out <= 9'd0;
        end else begin
            state <= state_nx;

            if (start_frame) begin
                step <= 6'd0;
            end else if (word_done && (step != LCD_LAST_STEP)) begin
                step <= step + 6'd1;
            end

            // A request in the same cycle the frame starts still counts,
            // so it yields one more frame rather than being lost.
            if (req) begin
                pending <= 1'b1;
            end else if (start_frame) begin
                pending <= 1'b0;
            end

            if (state == STROBE) begin
                tmo_cnt <= '0;
            end else if (state == ACK) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            if (state == LOAD) begin
                lcd.d_out <= word_nx;
            end
        end
    end

    assign lcd.data_ready = (state == STROBE);
    assign idle           = (state == IDLE) && !pending;

endmodule

// File: tb/tb_lcd_text_feeder.sv
// tb_lcd_text_feeder: directed bench for lcd_text_feeder with a busy-flag
// responder (busy rises 2 cycles after a strobe, held 10 cycles).
module tb_lcd_text_feeder;

    logic       clock = 1'b0;
    logic       internal_reset;
    logic       char_we;
    logic [4:0] char_addr;
    logic [7:0] char_data;
    logic       refresh;
    logic       idle;

    logic       boot_busy;
    logic       resp_mode;
    logic       resp_busy;
    int         rc = 0;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         b2b = 0;
    logic       dr_prev = 1'b0;
    int         ignore_idx = -1;

    logic [8:0] acc_q[$];
    int         scyc_q[$];
    logic [8:0] sw_q[$];
    logic [7:0] exp_buf [32];

    always #5 clock = ~clock;

    lcd_text_feeder_if lcd ();

    assign resp_busy    = (rc >= 3) && (rc <= 12);
    assign lcd.lcd_busy = resp_mode ? resp_busy : boot_busy;

    lcd_text_feeder dut (
        .clock          (clock),
        .internal_reset (internal_reset),
        .char_we        (char_we),
        .char_addr      (char_addr),
        .char_data      (char_data),
        .refresh        (refresh),
        .lcd            (lcd.master),
        .idle           (idle)
    );

    // Driver model and strobe log, sampled on the falling edge.
    always @(negedge clock) begin
        cyc     <= cyc + 1;
        dr_prev <= lcd.data_ready;
        if (lcd.data_ready && dr_prev) b2b <= b2b + 1;
        if (internal_reset) begin
            rc <= 0;
        end else if (lcd.data_ready && rc == 0 && resp_mode) begin
            if (scyc_q.size() != ignore_idx) begin
                acc_q.push_back(lcd.d_out);
                rc <= 1;
            end
        end else if (rc != 0) begin
            rc <= (rc == 13) ? 0 : rc + 1;
        end
        if (lcd.data_ready) begin
            scyc_q.push_back(cyc);
            sw_q.push_back(lcd.d_out);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        @(negedge clock);
        refresh = 1'b0;
    endtask

    task automatic write_char(input logic [4:0] a, input logic [7:0] d);
        char_we   = 1'b1;
        char_addr = a;
        char_data = d;
        @(negedge clock);
        char_we   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        tick(2);
        while (!idle && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk({tag, "_idle"}, 32'(idle), 32'd1);
    endtask

    task automatic wait_acc(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (acc_q.size() < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk({tag, "_reached"}, 32'(acc_q.size() >= n), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int start);
        logic [8:0] exp_w;
        logic [8:0] got_w;
        for (int i = 0; i < 34; i++) begin
            if (i == 0)       exp_w = 9'h080;
            else if (i <= 16) exp_w = {1'b1, exp_buf[i-1]};
            else if (i == 17) exp_w = 9'h0C0;
            else              exp_w = {1'b1, exp_buf[i-2]};
            got_w = (start + i < acc_q.size()) ? acc_q[start + i] : 9'h1FF;
            chk($sformatf("%s_w%0d", tag, i), 32'(got_w), 32'(exp_w));
        end
    endtask

    initial begin
        int base;
        int sidx;
        int c0;

        internal_reset = 1'b1;
        boot_busy = 1'b0;
        resp_mode = 1'b0;
        refresh   = 1'b0;
        char_we   = 1'b0;
        char_addr = 5'd0;
        char_data = 8'd0;
        for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;

        // Reset state
        tick(3);
        chk("rst_d_out", 32'(lcd.d_out), 32'h0);
        chk("rst_data_ready", 32'(lcd.data_ready), 32'h0);
        chk("rst_idle", 32'(idle), 32'h0);
        internal_reset = 1'b0;

        // Boot: busy low 5, high 100, then low
        tick(5);
        boot_busy = 1'b1;
        tick(100);
        chk("boot_no_strobe", 32'(scyc_q.size()), 32'd0);
        boot_busy = 1'b0;
        chk("boot_idle_before", 32'(idle), 32'd0);
        @(negedge clock);
        chk("boot_idle_after", 32'(idle), 32'd1);
        chk("boot_no_strobe_after", 32'(scyc_q.size()), 32'd0);
        resp_mode = 1'b1;
        tick(2);

        // Default frame and refresh latency
        base = acc_q.size();
        sidx = scyc_q.size();
        c0   = cyc;
        pulse_refresh();
        wait_idle("dflt", 1500);
        chk("refresh_latency", 32'((scyc_q.size() > sidx) ? scyc_q[sidx] - c0 : -1), 32'd3);
        check_frame("dflt", base);
        chk("dflt_count", 32'(acc_q.size() - base), 32'd34);

        // Content; second write lands in the same cycle as refresh
        write_char(5'd0, 8'h48);
        exp_buf[0] = 8'h48;
        char_we   = 1'b1;
        char_addr = 5'd31;
        char_data = 8'h3D;
        refresh   = 1'b1;
        base = acc_q.size();
        @(negedge clock);
        char_we = 1'b0;
        refresh = 1'b0;
        exp_buf[31] = 8'h3D;
        wait_idle("content", 1500);
        chk("content_w1", 32'((acc_q.size() > base + 1) ? acc_q[base + 1] : 9'h0), 32'h148);
        chk("content_w33", 32'((acc_q.size() > base + 33) ? acc_q[base + 33] : 9'h0), 32'h13D);
        check_frame("content", base);
        chk("content_count", 32'(acc_q.size() - base), 32'd34);

        // Coalescing: three requests during step 10
        base = acc_q.size();
        pulse_refresh();
        wait_acc("coal", base + 11, 600);
        pulse_refresh();
        tick(1);
        pulse_refresh();
        tick(1);
        pulse_refresh();
        wait_idle("coal", 3000);
        tick(40);
        chk("coal_count", 32'(acc_q.size() - base), 32'd68);
        chk("coal_idle_stays", 32'(idle), 32'd1);
        check_frame("coal_a", base);
        check_frame("coal_b", base + 34);

        // Timeout: first strobe of the frame is ignored
        base = acc_q.size();
        sidx = scyc_q.size();
        ignore_idx = sidx;
        pulse_refresh();
        wait_idle("tmo", 2500);
        ignore_idx = -1;
        chk("tmo_gap", 32'((scyc_q.size() > sidx + 1) ? scyc_q[sidx + 1] - scyc_q[sidx] : -1), 32'd256);
        chk("tmo_word0", 32'((sw_q.size() > sidx) ? sw_q[sidx] : 9'h0), 32'h080);
        chk("tmo_same_word", 32'((sw_q.size() > sidx + 1) ? sw_q[sidx + 1] : 9'h0), 32'((sw_q.size() > sidx) ? sw_q[sidx] : 9'h1FF));
        check_frame("tmo", base);
        chk("tmo_count", 32'(acc_q.size() - base), 32'd34);

        // Reset at step 20
        base = acc_q.size();
        pulse_refresh();
        wait_acc("rst20", base + 21, 600);
        tick(3);
        resp_mode = 1'b0;
        boot_busy = 1'b0;
        internal_reset = 1'b1;
        #1;
        chk("rst20_d_out", 32'(lcd.d_out), 32'h0);
        chk("rst20_data_ready", 32'(lcd.data_ready), 32'h0);
        chk("rst20_idle", 32'(idle), 32'h0);
        @(negedge clock);
        internal_reset = 1'b0;
        for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
        sidx = scyc_q.size();
        pulse_refresh();
        tick(3);
        boot_busy = 1'b1;
        tick(10);
        chk("reboot_no_strobe", 32'(scyc_q.size() - sidx), 32'd0);
        chk("reboot_idle_low", 32'(idle), 32'd0);
        base = acc_q.size();
        boot_busy = 1'b0;
        resp_mode = 1'b1;
        wait_idle("reboot", 1500);
        check_frame("reboot", base);
        chk("reboot_count", 32'(acc_q.size() - base), 32'd34);

        chk("no_b2b_strobe", 32'(b2b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
